// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and the write-back entry type
package regfile_pkg;
   localparam int XLEN       = 32;
   localparam int REG_AW     = 5;
   localparam int NUM_WPORTS = 4;
   typedef struct packed {
      logic [REG_AW-1:0] waddr;
      logic [XLEN-1:0]   wdata;
   } wb_entry_t;
endpackage

// File: rtl/wb_src_fifo.sv
// wb_src_fifo: per-source write-back buffer; a pushed entry reaches head only on the next cycle
module wb_src_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t din,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);
   localparam int PW = $clog2(DEPTH);
   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          do_push, do_pop;
   assign head    = mem[rd_ptr];
   assign full    = count == (PW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // storage, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
   // pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: buffers execution-unit results and issues up to four conflict-free register writes per cycle
// Optional stall counter output o_stall_cnt when WB_STALL_CNT_EN is defined.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_SRC    = 6,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_SRC-1:0]        i_valid,
   output logic [NUM_SRC-1:0]        o_ready,
   input  logic [NUM_SRC*REG_AW-1:0] i_waddr,
   input  logic [NUM_SRC*XLEN-1:0]   i_wdata,
   output logic                      o_we0,
   output logic                      o_we1,
   output logic                      o_we2,
   output logic                      o_we3,
   output logic [REG_AW-1:0]         o_waddr0,
   output logic [REG_AW-1:0]         o_waddr1,
   output logic [REG_AW-1:0]         o_waddr2,
   output logic [REG_AW-1:0]         o_waddr3,
   output logic [XLEN-1:0]           o_wdata0,
   output logic [XLEN-1:0]           o_wdata1,
   output logic [XLEN-1:0]           o_wdata2,
   output logic [XLEN-1:0]           o_wdata3,
`ifdef WB_STALL_CNT_EN
   output logic [31:0]               o_stall_cnt,
`endif
   output logic                      o_busy
);
   localparam int SW = $clog2(NUM_SRC);
   wb_entry_t               heads [NUM_SRC];
   logic [NUM_SRC-1:0]      push, pop, full, empty;
   logic                    ready_en;
   logic [SW-1:0]           rr, rr_nxt, idx;
   logic [2:0]              used;
   logic                    hit;
   wb_entry_t               slot [NUM_WPORTS];
   logic [NUM_WPORTS-1:0]   slot_we, we;
   logic [REG_AW-1:0]       waddr [NUM_WPORTS];
   logic [XLEN-1:0]         wdata [NUM_WPORTS];
   assign o_ready = {NUM_SRC{ready_en}} & ~full;
   assign push    = i_valid & o_ready;
   assign o_busy  = ~&empty;
   assign {o_we3, o_we2, o_we1, o_we0} = we;
   assign o_waddr0 = waddr[0];
   assign o_waddr1 = waddr[1];
   assign o_waddr2 = waddr[2];
   assign o_waddr3 = waddr[3];
   assign o_wdata0 = wdata[0];
   assign o_wdata1 = wdata[1];
   assign o_wdata2 = wdata[2];
   assign o_wdata3 = wdata[3];
   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      wb_entry_t din;
      assign din = {i_waddr[REG_AW*k +: REG_AW], i_wdata[XLEN*k +: XLEN]};
      wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk(i_clk), .rst_n(i_rst_n), .push(push[k]), .pop(pop[k]),
         .din(din), .head(heads[k]), .full(full[k]), .empty(empty[k])
      );
   end
   // rotating scan from rr: drop x0 heads, skip registers already granted, fill ports in order
   always_comb begin
      pop     = '0;
      slot_we = '0;
      for (int p = 0; p < NUM_WPORTS; p++) slot[p] = '0;
      used   = '0;
      rr_nxt = rr;
      idx    = '0;
      hit    = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         idx = SW'((int'(rr) + i) % NUM_SRC);
         hit = 1'b0;
         for (int p = 0; p < NUM_WPORTS; p++) hit |= slot_we[p] && slot[p].waddr == heads[idx].waddr;
         if (!empty[idx] && heads[idx].waddr == '0) pop[idx] = 1'b1;
         else if (!empty[idx] && !hit && used < 3'(NUM_WPORTS)) begin
            pop[idx]            = 1'b1;
            slot_we[used[1:0]]  = 1'b1;
            slot[used[1:0]]     = heads[idx];
            used                = used + 3'd1;
            rr_nxt              = SW'((int'(idx) + 1) % NUM_SRC);
         end
      end
   end
   // register granted entries onto their ports; idle ports keep address and data
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         we       <= '0;
         rr       <= '0;
         ready_en <= 1'b0;
         for (int p = 0; p < NUM_WPORTS; p++) begin
            waddr[p] <= '0;
            wdata[p] <= '0;
         end
      end else begin
         we       <= slot_we;
         rr       <= rr_nxt;
         ready_en <= 1'b1;
         for (int p = 0; p < NUM_WPORTS; p++) begin
            if (slot_we[p]) begin
               waddr[p] <= slot[p].waddr;
               wdata[p] <= slot[p].wdata;
            end
         end
      end
   end
`ifdef WB_STALL_CNT_EN
   // saturating count of edges where a source offered data that could not be taken
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_stall_cnt <= '0;
      else if (|(i_valid & ~o_ready) && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for the write-back arbiter
module tb_regfile_wb_arbiter;
   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b1;
   logic [5:0]   i_valid = '0;
   logic [5:0]   o_ready;
   logic [29:0]  i_waddr = '0;
   logic [191:0] i_wdata = '0;
   logic         o_we0, o_we1, o_we2, o_we3;
   logic [4:0]   o_waddr0, o_waddr1, o_waddr2, o_waddr3;
   logic [31:0]  o_wdata0, o_wdata1, o_wdata2, o_wdata3;
   logic         o_busy;
`ifdef WB_STALL_CNT_EN
   logic [31:0]  o_stall_cnt;
`endif
   logic [3:0]   we_v;
   int           checks = 0;
   int           errors = 0;

   assign we_v = {o_we3, o_we2, o_we1, o_we0};

   regfile_wb_arbiter #(.NUM_SRC(6), .FIFO_DEPTH(2)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_waddr(i_waddr), .i_wdata(i_wdata),
      .o_we0(o_we0), .o_we1(o_we1), .o_we2(o_we2), .o_we3(o_we3),
      .o_waddr0(o_waddr0), .o_waddr1(o_waddr1), .o_waddr2(o_waddr2), .o_waddr3(o_waddr3),
      .o_wdata0(o_wdata0), .o_wdata1(o_wdata1), .o_wdata2(o_wdata2), .o_wdata3(o_wdata3),
`ifdef WB_STALL_CNT_EN
      .o_stall_cnt(o_stall_cnt),
`endif
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_src(input int k, input logic [4:0] a, input logic [31:0] d);
      i_waddr[5*k +: 5]   = a;
      i_wdata[32*k +: 32] = d;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      i_valid = '0;
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // power-on reset
      #1 i_rst_n = 1'b0;
      #2;
      chk("rst_ready", 32'(o_ready), 32'h0);
      chk("rst_we", 32'(we_v), 32'h0);
      chk("rst_busy", 32'(o_busy), 32'h0);
      chk("rst_waddr0", 32'(o_waddr0), 32'h0);
      chk("rst_wdata3", o_wdata3, 32'h0);
      tick();
      i_rst_n = 1'b1;
      tick();
      chk("ready_after_release", 32'(o_ready), 32'h3F);
`ifdef WB_STALL_CNT_EN
      chk("stall_after_reset", o_stall_cnt, 32'h0);
`endif
      // single write, two-edge latency
      set_src(0, 5'd5, 32'hDEADBEEF);
      i_valid = 6'b000001;
      tick();
      i_valid = '0;
      chk("single_we_early", 32'(we_v), 32'h0);
      chk("single_busy", 32'(o_busy), 32'h1);
      tick();
      chk("single_we", 32'(we_v), 32'h1);
      chk("single_waddr0", 32'(o_waddr0), 32'd5);
      chk("single_wdata0", o_wdata0, 32'hDEADBEEF);
      chk("single_busy_done", 32'(o_busy), 32'h0);
      tick();
      chk("single_we_off", 32'(we_v), 32'h0);
      chk("single_waddr0_hold", 32'(o_waddr0), 32'd5);
      // backpressure with rr=1: src0 has three entries, src1..5 one each
      set_src(0, 5'd8, 32'hB0);
      for (int k = 1; k < 6; k++) set_src(k, 5'(10 + k), 32'hC0 + 32'(k));
      i_valid = 6'h3F;
      tick();
      chk("bp_ready_e1", 32'(o_ready), 32'h3F);
      chk("bp_we_e1", 32'(we_v), 32'h0);
      set_src(0, 5'd9, 32'hB1);
      i_valid = 6'b000001;
      tick();
      chk("bp_we_e2", 32'(we_v), 32'hF);
      chk("bp_waddr0_e2", 32'(o_waddr0), 32'd11);
      chk("bp_waddr1_e2", 32'(o_waddr1), 32'd12);
      chk("bp_waddr2_e2", 32'(o_waddr2), 32'd13);
      chk("bp_waddr3_e2", 32'(o_waddr3), 32'd14);
      chk("bp_ready_full", 32'(o_ready), 32'h3E);
      set_src(0, 5'd10, 32'hB2);
      tick();
      chk("bp_we_e3", 32'(we_v), 32'h3);
      chk("bp_waddr0_e3", 32'(o_waddr0), 32'd15);
      chk("bp_waddr1_e3", 32'(o_waddr1), 32'd8);
      chk("bp_wdata1_e3", o_wdata1, 32'hB0);
      chk("bp_waddr2_hold", 32'(o_waddr2), 32'd13);
      chk("bp_ready_e3", 32'(o_ready), 32'h3F);
`ifdef WB_STALL_CNT_EN
      chk("bp_stall_cnt", o_stall_cnt, 32'h1);
`endif
      tick();
      i_valid = '0;
      chk("bp_we_e4", 32'(we_v), 32'h1);
      chk("bp_waddr0_e4", 32'(o_waddr0), 32'd9);
      chk("bp_wdata0_e4", o_wdata0, 32'hB1);
      tick();
      chk("bp_we_e5", 32'(we_v), 32'h1);
      chk("bp_waddr0_e5", 32'(o_waddr0), 32'd10);
      chk("bp_wdata0_e5", o_wdata0, 32'hB2);
      chk("bp_busy_e5", 32'(o_busy), 32'h0);
      tick();
      chk("bp_we_e6", 32'(we_v), 32'h0);
      // six sources, distinct registers, rr back to 0
      do_reset();
      for (int k = 0; k < 6; k++) set_src(k, 5'(k + 1), 32'h100 + 32'(k));
      i_valid = 6'h3F;
      tick();
      i_valid = '0;
      tick();
      chk("six_we_a", 32'(we_v), 32'hF);
      chk("six_waddr0_a", 32'(o_waddr0), 32'd1);
      chk("six_waddr1_a", 32'(o_waddr1), 32'd2);
      chk("six_waddr2_a", 32'(o_waddr2), 32'd3);
      chk("six_waddr3_a", 32'(o_waddr3), 32'd4);
      chk("six_wdata0_a", o_wdata0, 32'h100);
      tick();
      chk("six_we_b", 32'(we_v), 32'h3);
      chk("six_waddr0_b", 32'(o_waddr0), 32'd5);
      chk("six_waddr1_b", 32'(o_waddr1), 32'd6);
      chk("six_wdata1_b", o_wdata1, 32'h105);
      chk("six_waddr2_hold", 32'(o_waddr2), 32'd3);
      tick();
      chk("six_we_c", 32'(we_v), 32'h0);
      chk("six_busy_c", 32'(o_busy), 32'h0);
      // same-register collision, src1 ahead of src2 from rr=0
      set_src(1, 5'd7, 32'hA1);
      set_src(2, 5'd7, 32'hA2);
      i_valid = 6'b000110;
      tick();
      i_valid = '0;
      tick();
      chk("col_we_first", 32'(we_v), 32'h1);
      chk("col_waddr0_first", 32'(o_waddr0), 32'd7);
      chk("col_wdata0_first", o_wdata0, 32'hA1);
      tick();
      chk("col_we_second", 32'(we_v), 32'h1);
      chk("col_wdata0_second", o_wdata0, 32'hA2);
      // x0 write is dropped
      set_src(3, 5'd0, 32'h1234);
      i_valid = 6'b001000;
      tick();
      i_valid = '0;
      chk("x0_we_accept", 32'(we_v), 32'h0);
      chk("x0_busy", 32'(o_busy), 32'h1);
      tick();
      chk("x0_we_drop", 32'(we_v), 32'h0);
      chk("x0_busy_drained", 32'(o_busy), 32'h0);
      tick();
      chk("x0_we_after", 32'(we_v), 32'h0);
      // reset mid-stream with four entries queued and one write on the ports
      set_src(4, 5'd20, 32'hE4);
      i_valid = 6'b010000;
      tick();
      for (int k = 0; k < 4; k++) set_src(k, 5'(16 + k), 32'hF0 + 32'(k));
      i_valid = 6'b001111;
      tick();
      i_valid = '0;
      chk("mid_we_pre", 32'(we_v), 32'h1);
      chk("mid_waddr0_pre", 32'(o_waddr0), 32'd20);
      chk("mid_busy_pre", 32'(o_busy), 32'h1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("mid_we_rst", 32'(we_v), 32'h0);
      chk("mid_waddr0_rst", 32'(o_waddr0), 32'h0);
      chk("mid_wdata0_rst", o_wdata0, 32'h0);
      chk("mid_busy_rst", 32'(o_busy), 32'h0);
      chk("mid_ready_rst", 32'(o_ready), 32'h0);
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      chk("mid_ready_release", 32'(o_ready), 32'h3F);
`ifdef WB_STALL_CNT_EN
      chk("mid_stall_cnt", o_stall_cnt, 32'h0);
`endif
      for (int c = 0; c < 3; c++) begin
         chk("mid_we_after", 32'(we_v), 32'h0);
         chk("mid_busy_after", 32'(o_busy), 32'h0);
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back side of the 4-write/8-read integer register file.
- Collects results from NUM_SRC execution units (ALU, MUL/DIV, LSU) through valid/ready channels and buffers them per source.
- Each cycle it issues up to 4 registered writes, driving the register file's four write ports directly.
- Guarantees no two writes to the same register in one cycle and drops writes to x0.

Parameters:
- NUM_SRC, 6, number of producer channels (2..8).
- FIFO_DEPTH, 2, entries per source FIFO (power of 2, >=2).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  NUM_SRC  per-source result valid.
- o_ready  output  NUM_SRC  per-source accept; high when that source's FIFO is not full.
- i_waddr  input  NUM_SRC*5  destination register per source; source k occupies bits [5k+4:5k].
- i_wdata  input  NUM_SRC*32  result data per source; source k occupies bits [32k+31:32k].
- o_we0..o_we3  output  1 each  register file write enables.
- o_waddr0..o_waddr3  output  5 each  register file write addresses.
- o_wdata0..o_wdata3  output  32 each  register file write data.
- o_busy  output  1  any source FIFO non-empty.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - All FIFOs empty.
  - o_we*, o_waddr*, o_wdata* = 0.
  - Round-robin pointer rr = 0.
  - o_ready forced to all 0 while reset is asserted; all 1 on the first edge after release.
  - o_busy = 0.
  - Reset mid-operation discards all buffered entries with no write issued.
- Accept:
  - A transfer occurs on an edge where i_valid[k] & o_ready[k]; the {waddr, wdata} entry is pushed into FIFO k.
  - o_ready[k] = !full[k], computed from the current count only. A pop in the same cycle does not raise ready.
  - i_valid without ready: the source holds its data; the block takes no action.
- Grant (combinational, each cycle):
  - Scan FIFO heads in order rr, rr+1, ..., rr+NUM_SRC-1 (mod NUM_SRC).
  - Head with waddr==0: popped and discarded. It consumes no port and does not count toward the 4.
  - Head with waddr equal to a head already granted this cycle: skipped, stays queued.
  - Otherwise granted to the next free port (0, then 1, 2, 3) until 4 ports are used.
  - Each source grants at most 1 entry per cycle.
- Issue:
  - Granted entries are popped and registered into o_we/o_waddr/o_wdata of their port.
  - Unused ports have o_we = 0; o_waddr/o_wdata hold their previous values.
- Latency:
  - Accepted on edge N; o_weX high during the cycle after edge N+1, i.e. 2 edges minimum.
- rr update:
  - If at least one entry was granted, rr = (index of last granted source + 1) mod NUM_SRC.
  - Otherwise rr is unchanged. Discarded x0 entries do not move rr.
- Per-source ordering:
  - Strictly FIFO.
  - Cross-source ordering to the same register: the older-queued entry is not guaranteed to win. Producers must not issue two in-flight writes to one architectural register.
- FIFO boundaries:
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
  - A push into an empty FIFO is not grantable until the next cycle (no bypass).
- o_busy = OR of all FIFO non-empty flags (combinational).

Optional Feature:
- Macro: WB_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt [31:0]. It increments on each edge where any i_valid[k] & !o_ready[k].
  - Saturates at 32'hFFFFFFFF and resets to 0.
- Undefined:
  - Port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package regfile_pkg:
  - XLEN=32, REG_AW=5, NUM_WPORTS=4.
  - Typedef wb_entry_t {logic [REG_AW-1:0] waddr; logic [XLEN-1:0] wdata;}.
- Sub-module wb_src_fifo: FIFO_DEPTH-entry synchronous FIFO.
  - Signals: push, pop, head, full, empty.
  - Asynchronous active-low reset.
  - Instantiated NUM_SRC times.
- Grant scan and output registers live in the top module.

Test Plan:
- Reset then one write: src0 sends {x5, 32'hDEADBEEF} -> o_we0=1, o_waddr0=5, o_wdata0=DEADBEEF exactly 2 edges after accept; all other o_we=0.
- Six sources valid together, distinct addresses x1..x6, rr=0:
  - Cycle A: ports 0..3 write x1..x4, rr becomes 4.
  - Next cycle: ports 0..1 write x5, x6.
- Address collision: src1 and src2 both target x7 in the same cycle -> only src1 is written first; src2's x7 write appears one cycle later.
- x0 drop: src3 sends {x0, 32'h1234} -> never appears on any o_we; FIFO drains; o_busy returns to 0.
- Backpressure: hold src0 valid with 3 entries and 5 sources also valid (FIFO_DEPTH=2) -> o_ready[0] goes 0 after 2 accepts; all entries are eventually written in per-source order.
- Reset mid-stream: assert i_rst_n low with 4 entries queued -> all o_we=0 immediately; no queued entry is ever written after release. With WB_STALL_CNT_EN defined, o_stall_cnt=0.
